// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage register for the five-stage MIPS core.
// Carries an opaque payload plus PC, branch-delay flag and exception code.
// Per-cycle action priority: req > eret > hold > bubble > advance.
// Two saturating counters record bubbles inserted and req/eret flushes.
module pipe_stage_reg #(
  parameter int unsigned        DATA_W   = 128,
  parameter int unsigned        PC_W     = 32,
  parameter int unsigned        EXC_W    = 5,
  parameter logic [PC_W-1:0]    RESET_PC = 32'h0000_3000,
  parameter logic [PC_W-1:0]    EXC_PC   = 32'h0000_4180,
  parameter int unsigned        CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic              eret_i,
  input  logic [PC_W-1:0]   epc_i,
  input  logic              hold_i,
  input  logic              bubble_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [PC_W-1:0]   in_pc_i,
  input  logic              in_bd_i,
  input  logic [EXC_W-1:0]  in_exc_i,
  input  logic [EXC_W-1:0]  local_exc_i,
  input  logic              cnt_clr_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [PC_W-1:0]   out_pc_o,
  output logic              out_bd_o,
  output logic [EXC_W-1:0]  out_exc_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [PC_W-1:0]   pc_q,    pc_d;
  logic              bd_q,    bd_d;
  logic [EXC_W-1:0]  exc_q,   exc_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q,  flush_cnt_d;

  logic             flush_evt;
  logic             bubble_evt;
  logic [EXC_W-1:0] exc_merged;

  // A flush is never masked by hold; a bubble only counts when it actually lands.
  assign flush_evt  = req_i | eret_i;
  assign bubble_evt = ~flush_evt & ~hold_i & bubble_i;

  // Earlier-stage exception code always wins over one raised in the upstream stage.
  assign exc_merged = (in_exc_i != '0) ? in_exc_i : local_exc_i;

  // Next-state payload selection in priority order.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    bd_d    = bd_q;
    exc_d   = exc_q;
    if (req_i) begin
      valid_d = 1'b0;
      data_d  = '0;
      bd_d    = 1'b0;
      exc_d   = '0;
      pc_d    = EXC_PC;
    end else if (eret_i) begin
      valid_d = 1'b0;
      data_d  = '0;
      bd_d    = 1'b0;
      exc_d   = '0;
      pc_d    = epc_i;
    end else if (hold_i) begin
      valid_d = valid_q;
    end else if (bubble_i) begin
      // PC and BD are kept so a later exception can still report the right EPC.
      valid_d = 1'b0;
      data_d  = '0;
      exc_d   = '0;
      pc_d    = in_pc_i;
      bd_d    = in_bd_i;
    end else begin
      valid_d = in_valid_i;
      data_d  = in_data_i;
      pc_d    = in_pc_i;
      bd_d    = in_bd_i;
      exc_d   = in_valid_i ? exc_merged : '0;
    end
  end

  // Saturating counters; clear beats any increment in the same cycle.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (cnt_clr_i) begin
      bubble_cnt_d = '0;
      flush_cnt_d  = '0;
    end else begin
      if (bubble_evt && (bubble_cnt_q != '1)) begin
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
      if (flush_evt && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  // Payload and counter registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      pc_q         <= RESET_PC;
      bd_q         <= 1'b0;
      exc_q        <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      pc_q         <= pc_d;
      bd_q         <= bd_d;
      exc_q        <= exc_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign out_valid_o  = valid_q;
  assign out_data_o   = data_q;
  assign out_pc_o     = pc_q;
  assign out_bd_o     = bd_q;
  assign out_exc_o    = exc_q;
  assign bubble_cnt_o = bubble_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default instance plus a CNT_W=2 instance
// sharing the same stimulus for counter saturation.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         reset;
  logic         req, eret, hold, bubble, in_valid, in_bd, cnt_clr;
  logic [31:0]  epc, in_pc;
  logic [127:0] in_data;
  logic [4:0]   in_exc, local_exc;

  logic         out_valid, out_bd;
  logic [127:0] out_data;
  logic [31:0]  out_pc;
  logic [4:0]   out_exc;
  logic [15:0]  bubble_cnt, flush_cnt;

  logic         s_valid, s_bd;
  logic [127:0] s_data;
  logic [31:0]  s_pc;
  logic [4:0]   s_exc;
  logic [1:0]   s_bubble_cnt, s_flush_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] PAT_A5 = {4{32'hA5A5_A5A5}};
  localparam logic [127:0] PAT_3C = {4{32'h3C3C_0F0F}};

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .eret_i(eret), .epc_i(epc),
    .hold_i(hold), .bubble_i(bubble), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_pc_i(in_pc), .in_bd_i(in_bd), .in_exc_i(in_exc), .local_exc_i(local_exc),
    .cnt_clr_i(cnt_clr), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_pc_o(out_pc), .out_bd_o(out_bd), .out_exc_o(out_exc),
    .bubble_cnt_o(bubble_cnt), .flush_cnt_o(flush_cnt)
  );

  pipe_stage_reg #(.CNT_W(2)) dut_sat (
    .clk_i(clk), .reset_i(reset), .req_i(req), .eret_i(eret), .epc_i(epc),
    .hold_i(hold), .bubble_i(bubble), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_pc_i(in_pc), .in_bd_i(in_bd), .in_exc_i(in_exc), .local_exc_i(local_exc),
    .cnt_clr_i(cnt_clr), .out_valid_o(s_valid), .out_data_o(s_data),
    .out_pc_o(s_pc), .out_bd_o(s_bd), .out_exc_o(s_exc),
    .bubble_cnt_o(s_bubble_cnt), .flush_cnt_o(s_flush_cnt)
  );

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 0; eret = 0; hold = 0; bubble = 0; cnt_clr = 0;
    in_valid = 0; in_bd = 0; in_pc = 32'h0; in_data = '0;
    in_exc = 0; local_exc = 0; epc = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", out_data); end
    checks++; if (out_pc !== 32'h3000) begin failures++; $display("FAIL rst_pc got=%h exp=00003000", out_pc); end
    checks++; if (out_bd !== 1'b0 || out_exc !== 5'd0) begin failures++; $display("FAIL rst_bd_exc got=%b/%0d exp=0/0", out_bd, out_exc); end
    checks++; if (bubble_cnt !== 16'd0 || flush_cnt !== 16'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", bubble_cnt, flush_cnt); end
    step();
    step();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_advance();
    in_valid = 1; in_pc = 32'h3004; in_data = PAT_A5; in_bd = 0;
    #1;
    checks++; if (out_pc !== 32'h3000) begin failures++; $display("FAIL adv_no_comb_path got=%h exp=00003000", out_pc); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3004) begin failures++; $display("FAIL adv_valid_pc got=%b/%h exp=1/00003004", out_valid, out_pc); end
    checks++; if (out_data !== PAT_A5) begin failures++; $display("FAIL adv_data got=%h exp=%h", out_data, PAT_A5); end
    in_pc = 32'h3008; in_bd = 1; in_data = PAT_3C;
    step();
    checks++; if (out_bd !== 1'b1 || out_data !== PAT_3C || out_pc !== 32'h3008) begin failures++; $display("FAIL adv_bd got=%b/%h/%h exp=1/%h/00003008", out_bd, out_data, out_pc, PAT_3C); end
    in_bd = 0;
  endtask

  task automatic test_exc_merge();
    in_valid = 1; in_exc = 0; local_exc = 4;
    step();
    checks++; if (out_exc !== 5'd4) begin failures++; $display("FAIL exc_local got=%0d exp=4", out_exc); end
    in_exc = 10; local_exc = 4;
    step();
    checks++; if (out_exc !== 5'd10) begin failures++; $display("FAIL exc_earlier got=%0d exp=10", out_exc); end
    in_valid = 0; in_exc = 0; local_exc = 4; in_pc = 32'h300C; in_bd = 1;
    step();
    checks++; if (out_exc !== 5'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL exc_invalid got=%0d/%b exp=0/0", out_exc, out_valid); end
    checks++; if (out_pc !== 32'h300C || out_bd !== 1'b1 || bubble_cnt !== 16'd0) begin failures++; $display("FAIL invalid_slot got=%h/%b/%0d exp=0000300c/1/0", out_pc, out_bd, bubble_cnt); end
    local_exc = 0; in_bd = 0;
  endtask

  task automatic test_bubble();
    bubble = 1; in_valid = 1; in_pc = 32'h3010; in_bd = 1; in_data = PAT_A5; in_exc = 3;
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== 128'h0 || out_exc !== 5'd0) begin failures++; $display("FAIL bub_clear got=%b/%h/%0d exp=0/0/0", out_valid, out_data, out_exc); end
    checks++; if (out_pc !== 32'h3010 || out_bd !== 1'b1) begin failures++; $display("FAIL bub_pc_bd got=%h/%b exp=00003010/1", out_pc, out_bd); end
    checks++; if (bubble_cnt !== 16'd1) begin failures++; $display("FAIL bub_cnt got=%0d exp=1", bubble_cnt); end
    hold = 1; in_pc = 32'h3050; in_bd = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_pc !== 32'h3010 || out_bd !== 1'b1 || out_valid !== 1'b0 || bubble_cnt !== 16'd1) begin failures++; $display("FAIL hold_bub%0d got=%h/%b/%b/%0d exp=00003010/1/0/1", i, out_pc, out_bd, out_valid, bubble_cnt); end
    end
    hold = 0; bubble = 0; in_exc = 0;
  endtask

  task automatic test_flush();
    in_valid = 1; in_pc = 32'h3030; in_data = PAT_3C; in_exc = 2;
    step();
    hold = 1; req = 1;
    step();
    checks++; if (out_pc !== 32'h4180 || out_valid !== 1'b0 || out_data !== 128'h0 || out_exc !== 5'd0) begin failures++; $display("FAIL hold_req got=%h/%b/%h/%0d exp=00004180/0/0/0", out_pc, out_valid, out_data, out_exc); end
    checks++; if (flush_cnt !== 16'd1) begin failures++; $display("FAIL hold_req_cnt got=%0d exp=1", flush_cnt); end
    eret = 1; epc = 32'h3020;
    step();
    checks++; if (out_pc !== 32'h4180 || flush_cnt !== 16'd2) begin failures++; $display("FAIL req_eret got=%h/%0d exp=00004180/2", out_pc, flush_cnt); end
    req = 0;
    step();
    checks++; if (out_pc !== 32'h3020 || out_valid !== 1'b0 || flush_cnt !== 16'd3) begin failures++; $display("FAIL eret got=%h/%b/%0d exp=00003020/0/3", out_pc, out_valid, flush_cnt); end
    checks++; if (bubble_cnt !== 16'd1) begin failures++; $display("FAIL flush_no_bub got=%0d exp=1", bubble_cnt); end
    eret = 0; hold = 0; in_exc = 0;
  endtask

  task automatic test_saturation();
    in_valid = 1; in_pc = 32'h3040; in_data = PAT_A5;
    cnt_clr = 1;
    step();
    checks++; if (s_bubble_cnt !== 2'd0 || s_flush_cnt !== 2'd0 || bubble_cnt !== 16'd0 || flush_cnt !== 16'd0) begin failures++; $display("FAIL clr got=%0d/%0d/%0d/%0d exp=0/0/0/0", s_bubble_cnt, s_flush_cnt, bubble_cnt, flush_cnt); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3040 || out_data !== PAT_A5) begin failures++; $display("FAIL clr_payload got=%b/%h exp=1/00003040", out_valid, out_pc); end
    cnt_clr = 0; bubble = 1;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++; if (s_bubble_cnt !== ((i > 3) ? 2'd3 : 2'(i))) begin failures++; $display("FAIL sat_bub%0d got=%0d exp=%0d", i, s_bubble_cnt, (i > 3) ? 3 : i); end
    end
    checks++; if (bubble_cnt !== 16'd5) begin failures++; $display("FAIL wide_bub got=%0d exp=5", bubble_cnt); end
    cnt_clr = 1;
    step();
    checks++; if (s_bubble_cnt !== 2'd0 || bubble_cnt !== 16'd0) begin failures++; $display("FAIL clr_bub got=%0d/%0d exp=0/0", s_bubble_cnt, bubble_cnt); end
    cnt_clr = 0; bubble = 0; req = 1;
    for (int i = 0; i < 4; i++) step();
    checks++; if (s_flush_cnt !== 2'd3 || flush_cnt !== 16'd4) begin failures++; $display("FAIL sat_flush got=%0d/%0d exp=3/4", s_flush_cnt, flush_cnt); end
    req = 0;
  endtask

  task automatic test_async_reset();
    in_valid = 1; in_pc = 32'h3060; in_data = PAT_3C; bubble = 1;
    step();
    bubble = 0;
    step();
    hold = 1;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3060 || bubble_cnt !== 16'd1) begin failures++; $display("FAIL pre_rst got=%b/%h/%0d exp=1/00003060/1", out_valid, out_pc, bubble_cnt); end
    #2;
    reset = 1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h3000 || out_data !== 128'h0) begin failures++; $display("FAIL async_rst got=%b/%h/%h exp=0/00003000/0", out_valid, out_pc, out_data); end
    checks++; if (bubble_cnt !== 16'd0 || flush_cnt !== 16'd0 || s_flush_cnt !== 2'd0) begin failures++; $display("FAIL async_rst_cnt got=%0d/%0d/%0d exp=0/0/0", bubble_cnt, flush_cnt, s_flush_cnt); end
    @(negedge clk);
    reset = 0;
    hold = 0; bubble = 1; in_pc = 32'h3070;
    step();
    checks++; if (bubble_cnt !== 16'd1 || s_bubble_cnt !== 2'd1 || out_pc !== 32'h3070) begin failures++; $display("FAIL post_rst got=%0d/%0d/%h exp=1/1/00003070", bubble_cnt, s_bubble_cnt, out_pc); end
    bubble = 0;
  endtask

  initial begin
    test_reset();
    test_advance();
    test_exc_merge();
    test_bubble();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core, replacing the hand-written per-stage registers (F/D, D/E, E/M, M/W) with one generic block. It carries an opaque control/data payload plus the PC, branch-delay flag and exception code. It supports exception redirect, eret redirect, bubble insertion and a full-stage hold. Each instance also keeps saturating bubble and flush counters for performance debug.

## Interface
Parameters:
- DATA_W, 128, width of the opaque payload (RD1/RD2/Imm32/regs/control fields packed by the instantiating stage)
- PC_W, 32, PC width
- EXC_W, 5, exception code width; code 0 = no exception
- RESET_PC, 32'h0000_3000, PC value after reset
- EXC_PC, 32'h0000_4180, PC loaded on exception request
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  1  exception taken this cycle; flush and redirect to EXC_PC
- eret  in  1  eret retiring; flush and redirect to epc
- epc  in  PC_W  return PC from CP0
- hold  in  1  freeze the stage: keep all registered outputs
- bubble  in  1  insert NOP: keep in_pc/in_bd, clear everything else
- in_valid  in  1  upstream slot holds a real instruction
- in_data  in  DATA_W  upstream payload
- in_pc  in  PC_W  upstream PC
- in_bd  in  1  upstream branch-delay flag
- in_exc  in  EXC_W  exception code carried from earlier stages
- local_exc  in  EXC_W  exception detected in the upstream stage this cycle
- cnt_clr  in  1  synchronous clear of both counters
- out_valid  out  1  registered valid
- out_data  out  DATA_W  registered payload
- out_pc  out  PC_W  registered PC
- out_bd  out  1  registered branch-delay flag
- out_exc  out  EXC_W  registered, merged exception code
- bubble_cnt  out  CNT_W  number of bubbles inserted, saturating
- flush_cnt  out  CNT_W  number of req/eret flushes, saturating

## Operation
- Reset values: out_valid=0, out_data=0, out_pc=RESET_PC, out_bd=0, out_exc=0, bubble_cnt=0, flush_cnt=0.
- Each rising edge, exactly one action applies, in priority order req > eret > hold > bubble > advance:
  - req: valid=0, data=0, bd=0, exc=0, pc=EXC_PC; flush_cnt+1.
  - eret (with req=0): same clears, pc=epc; flush_cnt+1.
  - hold: all payload registers unchanged. Counters are unchanged except when cnt_clr applies.
  - bubble: valid=0, data=0, exc=0, pc=in_pc, bd=in_bd; bubble_cnt+1. Keeping the PC and BD lets a later exception report the correct EPC.
  - advance: valid=in_valid, data=in_data, pc=in_pc, bd=in_bd. If in_valid=1, exc=(in_exc!=0)?in_exc:local_exc; otherwise exc=0. An earlier-stage code always wins.
- req and eret override hold. A flush must never be lost to a stalled stage.
- Counters saturate at all-ones and do not wrap. cnt_clr zeroes both counters and takes priority over any increment in the same cycle. cnt_clr does not affect the payload registers.
- The payload is opaque: the block never inspects in_data.

## Timing
- Latency is one cycle, from the in_* signals at edge N to the out_* signals after edge N.
- All outputs are registered. There is no combinational path from any input to any output.
- Reset is asserted asynchronously: outputs go to reset values immediately, without a clock edge.
- Reset release must be synchronised externally. The first action is taken at the first rising edge after deassertion.
- Reset asserted in the middle of a hold or bubble sequence discards all state. Counters return to 0.
- req and eret both high in the same cycle: req wins. pc=EXC_PC, and flush_cnt increments once.
- hold and bubble both high: hold wins, and bubble_cnt is not incremented.
- in_valid=0 on advance: the slot becomes a bubble that is not counted. pc and bd still follow the inputs.

## Test plan
- Reset with default parameters, then no clock edge: outputs are 0, out_pc=0x3000 immediately. Then advance with in_valid=1, in_pc=0x3004, in_data=0xA5…: outputs match one cycle later.
- Exception merge: in_exc=0, local_exc=4 -> out_exc=4. in_exc=10, local_exc=4 -> out_exc=10. in_valid=0, local_exc=4 -> out_exc=0.
- Bubble with in_pc=0x3010, in_bd=1 -> out_valid=0, out_data=0, out_pc=0x3010, out_bd=1; bubble_cnt goes 0->1. Then hold plus bubble for 3 cycles -> outputs and bubble_cnt unchanged.
- hold=1 with req=1 -> out_pc=0x4180, out_valid=0, flush_cnt+1. req and eret together with epc=0x3020 -> out_pc=0x4180. eret alone -> out_pc=0x3020.
- Saturation with CNT_W=2: 5 bubbles -> bubble_cnt=3. cnt_clr together with bubble -> bubble_cnt=0.
- Asynchronous reset pulse between clock edges during a hold -> outputs go to reset values before the next edge. After release the counters restart from 0.
